// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one single-outstanding bus between fetch and load/store ports.
// Data wins ties, but a pending fetch is forced through after STARVE_MAX consecutive data grants.
module cpu_bus_arbiter #(
   parameter int STARVE_MAX = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ok,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic        busy,
   output logic        err_spurious
);
   localparam int CW = $clog2(STARVE_MAX + 2);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} stateType;
   stateType state, nextState;
   logic ownerData, grantInst, starved, capture, spurious;
   logic [CW-1:0] starveCnt;
   always_comb begin
      starved   = starveCnt == CW'(STARVE_MAX);
      grantInst = inst_req && (!data_req || starved);
      capture   = bus_data_ok && (state == WAIT || (state == ADDR && bus_addr_ok));
      spurious  = bus_data_ok && !capture;
      bus_req   = state == ADDR;
      busy      = state != IDLE;
      inst_ok   = state == DONE && !ownerData;
      data_ok   = state == DONE && ownerData;
      nextState = state;
      case (state)
         IDLE:    nextState = (inst_req || data_req) ? ADDR : IDLE;
         ADDR:    nextState = bus_addr_ok ? (bus_data_ok ? DONE : WAIT) : ADDR;
         WAIT:    nextState = bus_data_ok ? DONE : WAIT;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ownerData    <= 1'b0;
         starveCnt    <= '0;
         bus_wr       <= 1'b0;
         bus_wstrb    <= '0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         inst_rdata   <= '0;
         data_rdata   <= '0;
         err_spurious <= 1'b0;
      end else begin
         state <= nextState;
         if (state == IDLE) begin
            if (inst_req || data_req) begin
               ownerData <= !grantInst;
               bus_addr  <= grantInst ? inst_addr : data_addr;
               bus_wr    <= !grantInst && data_wr;
               bus_wstrb <= (!grantInst && data_wr) ? data_wstrb : 4'b0000;
               bus_wdata <= grantInst ? 32'h0 : data_wdata;
            end
            // only a data grant made over a waiting fetch advances the starvation count
            starveCnt <= (!inst_req || grantInst) ? '0 : (starved ? starveCnt : starveCnt + CW'(1));
         end
         if (capture && !ownerData) inst_rdata <= bus_rdata;
         if (capture && ownerData && !bus_wr) data_rdata <= bus_rdata;
         if (spurious) err_spurious <= 1'b1;
      end
   end
endmodule
